multi_debouncer: RTL and testbench

- Parametrised, multi-channel successor to the single-button debouncer.
- Each of N_CH raw push-button/switch inputs is synchronised, debounced with a programmable stability window, and presented as a clean level.
- Each channel also produces one-cycle press, release and long-press pulses.
- Sits between board pins and the control FSMs; all outputs are in the clk domain.

---
 rtl/multi_debouncer_pkg.sv | 26 ++
 rtl/multi_debouncer_channel.sv | 116 +++++++++++
 rtl/multi_debouncer.sv | 43 ++++
 tb/tb_multi_debouncer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/multi_debouncer_pkg.sv
// Shared constants and helpers for the multi-channel push-button debouncer.
package multi_debouncer_pkg;

   localparam int DEF_DB_CYCLES   = 65536;
   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_HOLD_CYCLES = 0;

   // Registered one-cycle edge events of a single channel
   typedef struct packed {
      logic pressed;
      logic released;
   } edge_evt_t;

   // Width of a counter that must hold values 0..max_val; never narrower than one bit
   function automatic int cnt_width(input int max_val);
      int w;
      w = $clog2(max_val + 1);
      if (w < 1) begin
         w = 1;
      end else begin
         w = w;
      end
      return w;
   endfunction

endpackage

// File: rtl/multi_debouncer_channel.sv
// One debounce channel: synchroniser, stability counter, press/release pulses
// and an optional long-press hold counter.
module debounce_channel
   import multi_debouncer_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int DB_CYCLES   = DEF_DB_CYCLES,
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic pb_state,
   output logic pressed,
   output logic released,
   output logic long_press
);

   localparam int              DB_W    = cnt_width(DB_CYCLES);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   s_s;
   logic [DB_W-1:0]        db_cnt_r;
   logic [DB_W-1:0]        db_cnt_nxt_s;
   logic                   state_r;
   logic                   state_nxt_s;
   edge_evt_t              evt_r;

   // Synchroniser shift chain; the last stage is the only one the debouncer looks at
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_r <= {SYNC_STAGES{1'b0}};
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], raw};
      end
   end

   assign s_s = sync_r[SYNC_STAGES-1];

   // Next debounced level: any agreeing sample restarts the window
   always_comb begin
      state_nxt_s  = state_r;
      db_cnt_nxt_s = db_cnt_r;
      if (s_s == state_r) begin
         db_cnt_nxt_s = DB_W'(0);
      end else if (db_cnt_r == DB_LAST) begin
         state_nxt_s  = ~state_r;
         db_cnt_nxt_s = DB_W'(0);
      end else begin
         db_cnt_nxt_s = db_cnt_r + DB_W'(1);
      end
   end

   // Debounced level, counter and edge pulses, registered so pulses align with the new level
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= 1'b0;
         db_cnt_r       <= DB_W'(0);
         evt_r.pressed  <= 1'b0;
         evt_r.released <= 1'b0;
      end else begin
         state_r        <= state_nxt_s;
         db_cnt_r       <= db_cnt_nxt_s;
         evt_r.pressed  <= state_nxt_s & ~state_r;
         evt_r.released <= ~state_nxt_s & state_r;
      end
   end

   assign pb_state = state_r;
   assign pressed  = evt_r.pressed;
   assign released = evt_r.released;

   if (HOLD_CYCLES > 0) begin : g_hold
      localparam int              HOLD_W    = cnt_width(HOLD_CYCLES);
      localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
      localparam logic [HOLD_W-1:0] HOLD_FULL = HOLD_W'(HOLD_CYCLES);

      logic [HOLD_W-1:0] hold_cnt_r;
      logic [HOLD_W-1:0] hold_cnt_nxt_s;
      logic              long_r;
      logic              long_nxt_s;

      // Hold counting; a release on this edge wins over a hold expiry
      always_comb begin
         hold_cnt_nxt_s = hold_cnt_r;
         long_nxt_s     = 1'b0;
         if (!state_r || !state_nxt_s) begin
            hold_cnt_nxt_s = HOLD_W'(0);
         end else if (hold_cnt_r == HOLD_LAST) begin
            hold_cnt_nxt_s = HOLD_FULL;
            long_nxt_s     = 1'b1;
         end else if (hold_cnt_r < HOLD_LAST) begin
            hold_cnt_nxt_s = hold_cnt_r + HOLD_W'(1);
         end else begin
            hold_cnt_nxt_s = hold_cnt_r;
         end
      end

      // Hold counter and long-press pulse registers
      always_ff @(posedge clk) begin
         if (rst) begin
            hold_cnt_r <= HOLD_W'(0);
            long_r     <= 1'b0;
         end else begin
            hold_cnt_r <= hold_cnt_nxt_s;
            long_r     <= long_nxt_s;
         end
      end

      assign long_press = long_r;
   end else begin : g_no_hold
      assign long_press = 1'b0;
   end

endmodule

// File: rtl/multi_debouncer.sv
// Multi-channel push-button debouncer: per-bit polarity correction feeding
// independent debounce channels.
module multi_debouncer
   import multi_debouncer_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int DB_CYCLES   = DEF_DB_CYCLES,
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
   parameter int ACTIVE_LOW  = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] pb,
   output logic [N_CH-1:0] pb_state,
   output logic [N_CH-1:0] pressed,
   output logic [N_CH-1:0] released,
   output logic [N_CH-1:0] long_press
);

   localparam logic INV = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

   logic [N_CH-1:0] raw_s;

   assign raw_s = pb ^ {N_CH{INV}};

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_channel #(
         .SYNC_STAGES (SYNC_STAGES),
         .DB_CYCLES   (DB_CYCLES),
         .HOLD_CYCLES (HOLD_CYCLES)
      ) u_ch (
         .clk        (clk),
         .rst        (rst),
         .raw        (raw_s[i]),
         .pb_state   (pb_state[i]),
         .pressed    (pressed[i]),
         .released   (released[i]),
         .long_press (long_press[i])
      );
   end

endmodule

// File: tb/tb_multi_debouncer.sv
// Self-checking bench: directed scenarios plus random bouncing, compared every
// cycle against a window-based reference model of the debounce rules.
module tb_multi_debouncer;

   localparam int N    = 2;
   localparam int SYNC = 2;
   localparam int DB   = 4;
   localparam int HOLD = 10;
   localparam int RING = 64;

   logic         clk;
   logic         rst;
   logic [N-1:0] pb;
   logic [N-1:0] pb_al;
   logic [N-1:0] pb_state, pressed, released, long_press;
   logic [N-1:0] al_state, al_pressed, al_released, al_long;

   int n_checks = 0;
   int n_errors = 0;
   int obs_press0, obs_rel0, obs_long0;

   assign pb_al = ~pb;

   multi_debouncer #(.N_CH(N), .SYNC_STAGES(SYNC), .DB_CYCLES(DB),
                     .HOLD_CYCLES(HOLD), .ACTIVE_LOW(0)) dut (
      .clk(clk), .rst(rst), .pb(pb), .pb_state(pb_state),
      .pressed(pressed), .released(released), .long_press(long_press));

   multi_debouncer #(.N_CH(N), .SYNC_STAGES(SYNC), .DB_CYCLES(DB),
                     .HOLD_CYCLES(HOLD), .ACTIVE_LOW(1)) dut_al (
      .clk(clk), .rst(rst), .pb(pb_al), .pb_state(al_state),
      .pressed(al_pressed), .released(al_released), .long_press(al_long));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: edge index since reset, log of sampled raw values
   int           k;
   logic [N-1:0] raw_log [RING];
   logic [N-1:0] m_state, m_pressed, m_released, m_long;
   int           last_tg [N];
   int           press_e [N];

   // Value the debouncer compares at edge e: raw sampled SYNC edges earlier, 0 before that
   function automatic logic s_at(input int e, input int c);
      if (e - SYNC >= 1) return raw_log[(e - SYNC) % RING][c];
      else return 1'b0;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         k = 0;
         m_state = '0; m_pressed = '0; m_released = '0; m_long = '0;
         for (int c = 0; c < N; c++) begin
            last_tg[c] = 0;
            press_e[c] = -1;
         end
      end else begin
         k = k + 1;
         raw_log[k % RING] = pb;
         m_pressed = '0; m_released = '0; m_long = '0;
         for (int c = 0; c < N; c++) begin
            // Toggle once the last DB compared samples since the previous toggle all disagree
            bit flip;
            flip = (k - DB + 1 > last_tg[c]);
            for (int j = k - DB + 1; j <= k; j++)
               if (flip && s_at(j, c) == m_state[c]) flip = 0;
            if (flip) begin
               m_state[c] = ~m_state[c];
               last_tg[c] = k;
               if (m_state[c]) begin
                  m_pressed[c] = 1'b1;
                  press_e[c]   = k;
               end else begin
                  m_released[c] = 1'b1;
                  press_e[c]    = -1;
               end
            end
            m_long[c] = m_state[c] && press_e[c] >= 1 && k == press_e[c] + HOLD;
         end
      end
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One cycle: compare both DUTs against the model, tally pulses, then drive new inputs
   task automatic step(input logic r, input logic [N-1:0] p);
      @(negedge clk);
      check_val("pb_state", 32'(pb_state), 32'(m_state));
      check_val("pressed", 32'(pressed), 32'(m_pressed));
      check_val("released", 32'(released), 32'(m_released));
      check_val("long_press", 32'(long_press), 32'(m_long));
      check_val("al_pb_state", 32'(al_state), 32'(m_state));
      check_val("al_pressed", 32'(al_pressed), 32'(m_pressed));
      check_val("al_released", 32'(al_released), 32'(m_released));
      check_val("al_long_press", 32'(al_long), 32'(m_long));
      obs_press0 += int'(pressed[0]);
      obs_rel0   += int'(released[0]);
      obs_long0  += int'(long_press[0]);
      rst = r;
      pb  = p;
   endtask

   task automatic run(input logic [N-1:0] p, input int n);
      for (int i = 0; i < n; i++) step(1'b0, p);
   endtask

   task automatic clr_obs();
      obs_press0 = 0; obs_rel0 = 0; obs_long0 = 0;
   endtask

   initial begin
      logic [N-1:0] rv;
      int           dur [N];
      rst = 1'b1;
      pb  = 2'b11;
      clr_obs();

      // 1: reset with pb held, then exact 6-edge latency
      repeat (3) step(1'b1, 2'b11);
      check_val("t1_reset_state", 32'(pb_state | pressed | released | long_press), 32'd0);
      step(1'b0, 2'b11);
      run(2'b11, 5);
      check_val("t1_before_lat", 32'(pb_state), 32'd0);
      run(2'b11, 1);
      check_val("t1_after_lat", 32'(pb_state), 32'd3);
      check_val("t5_active_low", 32'(al_state), 32'd3);
      run(2'b00, 12);

      // 2: single-channel step
      clr_obs();
      run(2'b01, 20);
      check_val("t2_press_cnt", 32'(obs_press0), 32'd1);
      run(2'b00, 12);

      // 3: short glitch, then bouncing that finally settles high
      clr_obs();
      run(2'b01, 3);
      run(2'b00, 12);
      check_val("t3_glitch_press", 32'(obs_press0), 32'd0);
      check_val("t3_glitch_rel", 32'(obs_rel0), 32'd0);
      for (int i = 0; i < 10; i++) begin
         run(2'b01, 2);
         run(2'b00, 2);
      end
      run(2'b01, 8);
      check_val("t3_bounce_press", 32'(obs_press0), 32'd1);
      run(2'b00, 12);

      // 4: long hold produces exactly one long press
      clr_obs();
      run(2'b01, 30);
      run(2'b00, 12);
      check_val("t4_long_cnt", 32'(obs_long0), 32'd1);
      check_val("t4_rel_cnt", 32'(obs_rel0), 32'd1);

      // 5: short press, released before hold expiry
      clr_obs();
      run(2'b01, 8);
      run(2'b00, 12);
      check_val("t5_long_cnt", 32'(obs_long0), 32'd0);
      check_val("t5_rel_cnt", 32'(obs_rel0), 32'd1);

      // 6: reset mid-count and mid-hold
      clr_obs();
      run(2'b01, 4);
      step(1'b1, 2'b01);
      step(1'b1, 2'b01);
      step(1'b0, 2'b01);
      run(2'b01, 13);
      step(1'b1, 2'b01);
      step(1'b1, 2'b01);
      step(1'b0, 2'b01);
      check_val("t6_no_long_yet", 32'(obs_long0), 32'd0);
      run(2'b01, 25);
      check_val("t6_long_after", 32'(obs_long0), 32'd1);
      run(2'b00, 12);

      // Random bouncing with occasional resets
      rv = 2'b00;
      for (int c = 0; c < N; c++) dur[c] = 1;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         for (int c = 0; c < N; c++) begin
            dur[c]--;
            if (dur[c] <= 0) begin
               rv[c]  = ~rv[c];
               dur[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 30))
                                                    : int'($urandom_range(1, 7));
            end
         end
         step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, rv);
      end
      run(2'b00, 12);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
